key_debounce: RTL

Debounces and synchronises up to N_KEYS mechanical push-buttons (active-low, 0 = pressed) into clean, glitch-free active-low levels plus single-cycle press/release strobes. Sits directly upstream of the board's key-to-LED logic: its `key_out` bits drive the logic inputs (e.g. KEY1/KEY2 into the AND stage) in place of raw pins. Key and LED active-low polarity is preserved end to end.

---
 rtl/key_debounce_pkg.sv | 25 ++
 rtl/key_debounce_ch.sv | 110 +++++++++++
 rtl/key_debounce.sv | 28 ++
 3 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and polarity constants for the key debouncer.
// Keys and debounced levels are active-low throughout.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    UP           = 2'b00,
    PRESS_WAIT   = 2'b01,
    DOWN         = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_e;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Debounced level presented while sitting in a given state.
  function automatic logic level_of(input key_state_e st);
    logic lvl;
    case (st)
      DOWN, RELEASE_WAIT: lvl = KEY_PRESSED;
      default:            lvl = KEY_RELEASED;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, qualification counter,
// four-state FSM and registered level/strobe outputs.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_out,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic             sync1_r, sync2_r, key_s;
  key_state_e       state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             key_out_r, key_press_r, key_release_r;

  assign key_s = sync2_r;

  // Synchroniser: idles at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= KEY_RELEASED;
      sync2_r <= KEY_RELEASED;
    end else begin
      sync1_r <= key_in;
      sync2_r <= sync1_r;
    end
  end

  // Next-state and counter logic; any reversal during a wait aborts it.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      UP: begin
        cnt_next_s = CNT_ZERO;
        if (key_s == KEY_PRESSED) begin
          next_state_s = PRESS_WAIT;
        end else begin
          next_state_s = UP;
        end
      end
      PRESS_WAIT: begin
        if (key_s == KEY_RELEASED) begin
          next_state_s = UP;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          next_state_s = DOWN;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      DOWN: begin
        cnt_next_s = CNT_ZERO;
        if (key_s == KEY_RELEASED) begin
          next_state_s = RELEASE_WAIT;
        end else begin
          next_state_s = DOWN;
        end
      end
      RELEASE_WAIT: begin
        if (key_s == KEY_PRESSED) begin
          next_state_s = DOWN;
          cnt_next_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          next_state_s = UP;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        next_state_s = UP;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and outputs registered together so level and strobe align.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= UP;
      cnt_r         <= CNT_ZERO;
      key_out_r     <= KEY_RELEASED;
      key_press_r   <= 1'b0;
      key_release_r <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      cnt_r         <= cnt_next_s;
      key_out_r     <= level_of(next_state_s);
      key_press_r   <= (state_r == PRESS_WAIT)   && (next_state_s == DOWN);
      key_release_r <= (state_r == RELEASE_WAIT) && (next_state_s == UP);
    end
  end

  assign key_out     = key_out_r;
  assign key_press   = key_press_r;
  assign key_release = key_release_r;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: N_KEYS independent channels of active-low
// levels with single-cycle press/release strobes.
module key_debounce #(
  parameter int unsigned N_KEYS          = 32'd2,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[gi]),
      .key_out    (key_out[gi]),
      .key_press  (key_press[gi]),
      .key_release(key_release[gi])
    );
  end

endmodule
